// File: rtl/inst_memory_ctrl.sv
// inst_memory_ctrl
//   Instruction memory for the CPU data path. It has a registered read port and
//   a write port, which share one address. After reset is released, and again on
//   clear_req, a clear engine writes CLEAR_VAL to one word per cycle. While the
//   engine runs, busy is high and all accesses are ignored. Reads have a fixed
//   latency of one cycle. If an access targets addr >= DEPTH, addr_err pulses.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   rd_en      in   read request
//   wr_en      in   write request
//   addr       in   word address, shared by read and write
//   wdata      in   write data
//   clear_req  in   single-cycle pulse that starts a full clear
//   inj_par    in   (INSTMEM_PARITY_EN only) store the inverted parity on a write
//   par_err    out  (INSTMEM_PARITY_EN only) parity mismatch, aligned with rvalid
//   rdata      out  registered read data; holds its value when no read occurs
//   rvalid     out  single-cycle strobe, high when rdata is valid
//   addr_err   out  single-cycle pulse: the previous access was out of range
//   busy       out  high while the clear engine runs
//
// Configuration
//   INSTMEM_PARITY_EN  adds an even-parity bit to each word, plus the
//                      par_err and inj_par ports.

module inst_memory_ctrl #(
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          ADDR_W    = 16,
    parameter int unsigned          DEPTH     = 256,
    parameter logic [DATA_W-1:0]    CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clear_req,
`ifdef INSTMEM_PARITY_EN
    input  logic              inj_par,
    output logic              par_err,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              addr_err,
    output logic              busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef INSTMEM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   clr_ptr, clr_ptr_n;
    logic [DATA_W-1:0]  rdata_n;
    logic               rvalid_n, addr_err_n;

    logic [WORD_W-1:0]  mem [DEPTH];
    logic               mem_we;
    logic [PTR_W-1:0]   mem_idx;
    logic [WORD_W-1:0]  mem_word;

    logic               in_range;
    logic [PTR_W-1:0]   idx;
    logic [WORD_W-1:0]  rd_word;
    logic [WORD_W-1:0]  wr_word;
    logic [WORD_W-1:0]  clear_word;

    // The compare is one bit wider, so that DEPTH == 2**ADDR_W is handled correctly.
    assign in_range = ({1'b0, addr} < DEPTH_X);
    assign idx      = addr[PTR_W-1:0];
    assign rd_word  = mem[idx];

`ifdef INSTMEM_PARITY_EN
    logic par_err_n;
    // Even parity: the stored bit equals the XOR of the data bits.
    assign wr_word    = {(^wdata) ^ inj_par, wdata};
    assign clear_word = {^CLEAR_VAL, CLEAR_VAL};
`else
    assign wr_word    = wdata;
    assign clear_word = CLEAR_VAL;
`endif

    assign busy = (state == ST_CLEAR);

    always_comb begin
        state_n    = state;
        clr_ptr_n  = clr_ptr;
        rdata_n    = rdata;
        rvalid_n   = 1'b0;
        addr_err_n = 1'b0;
        mem_we     = 1'b0;
        mem_idx    = idx;
        mem_word   = wr_word;
`ifdef INSTMEM_PARITY_EN
        par_err_n  = 1'b0;
`endif
        case (state)
            ST_CLEAR: begin
                mem_we   = 1'b1;
                mem_idx  = clr_ptr;
                mem_word = clear_word;
                if (clr_ptr == LAST_PTR) begin
                    state_n = ST_IDLE;
                end else begin
                    clr_ptr_n = clr_ptr + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_n   = ST_CLEAR;
                    clr_ptr_n = '0;
                end else begin
                    if (rd_en) begin
                        rvalid_n = 1'b1;
                        rdata_n  = in_range ? rd_word[DATA_W-1:0] : '0;
`ifdef INSTMEM_PARITY_EN
                        par_err_n = in_range & (^rd_word);
`endif
                    end
                    addr_err_n = (rd_en | wr_en) & ~in_range;
                    mem_we     = wr_en & in_range;
                end
            end
            default: state_n = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_CLEAR;
            clr_ptr  <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_n;
            clr_ptr  <= clr_ptr_n;
            rdata    <= rdata_n;
            rvalid   <= rvalid_n;
            addr_err <= addr_err_n;
        end
    end

`ifdef INSTMEM_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_err <= 1'b0;
        end else begin
            par_err <= par_err_n;
        end
    end
`endif

    // The array has no reset; the clear engine initialises it. A read and a write
    // in the same cycle return the old word, because the read samples mem before
    // this nonblocking update takes effect.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_word;
        end
    end

endmodule
